booth_product_accumulator: RTL and testbench
============================================

// Module: booth_product_accumulator
// PURPOSE
//  Downstream consumer of the 4x4 Booth multiplier product P. Accepts signed
//  8-bit products over a valid/ready handshake and sums N_TERMS of them (or
//  fewer, ended early by in_last) into a sign-extended accumulator. Presents
//  the dot-product result with its own valid/ready handshake. Forms the MAC
//  back-end of the multiplier datapath.
// PARAMETERS
//  P_W     8   product width, signed two's complement (matches multiplier P)
//  ACC_W   16  accumulator/result width, signed; ACC_W >= P_W+1
//  N_TERMS 4   products per result; >= 1; CNT_W = $clog2(N_TERMS+1)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  clear       in   1      sync abort: drop partial sum and pending result
//  in_valid    in   1      in_product/in_last valid
//  in_ready    out  1      block can accept a product this cycle
//  in_product  in   P_W    signed product from multiplier
//  in_last     in   1      accepted product closes the current result early
//  out_valid   out  1      out_sum/out_count/out_ovf valid
//  out_ready   in   1      downstream accepts the result
//  out_sum     out  ACC_W  signed sum of accepted products
//  out_count   out  CNT_W  number of products in out_sum (1..N_TERMS)
//  out_ovf     out  1      signed overflow occurred while forming out_sum
// BEHAVIOUR
//  - Reset (async assert, sync release): state=ACCUM, acc=0, cnt=0, ovf=0;
//    outputs in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
//  - FSM, 2 states. ACCUM: in_ready=1, out_valid=0. HOLD: in_ready=0,
//    out_valid=1. All outputs registered; in_ready = (state==ACCUM).
//  - Accept = in_valid & in_ready. On accept: acc <= acc + sext(in_product)
//    to ACC_W; cnt <= cnt+1; ovf |= signed overflow of that add (operands
//    same sign, result sign differs).
//  - Accept with in_last=1 or cnt==N_TERMS-1 -> HOLD next cycle with the
//    updated sum on out_sum (latency 1 cycle from final accept). Both
//    conditions together: single close, no double count.
//  - HOLD: out_sum/out_count/out_ovf stable until out_valid & out_ready;
//    then ACCUM next cycle with acc=0, cnt=0, ovf=0. No accept in HOLD
//    (one bubble per result; accepted throughput N_TERMS per N_TERMS+1 clk).
//  - in_product ignored when in_valid=0 or in_ready=0.
//  - clear=1 (highest priority, any state): next cycle ACCUM, acc=0, cnt=0,
//    ovf=0, out_valid=0; same-cycle accept and result handshake discarded.
//  - N_TERMS=1: every accept closes a result.
//  - rst_n low mid-result: all state lost immediately, reset values above.
// CONFIGURATION
//  BOOTH_ACC_SAT_EN defined: each add saturates to +(2^(ACC_W-1)-1) or
//    -2^(ACC_W-1) on overflow; out_ovf still set (sticky) when any clamp hit.
//  Not defined: add wraps modulo 2^ACC_W; out_ovf flags the wrap.
// TESTING
//  1 Products 3,-2,7,-1, out_ready=1 -> out_valid 1 clk after 4th accept,
//    out_sum=16'h0007, out_count=4, out_ovf=0; in_ready low that cycle only.
//  2 Same stream, out_ready=0 for 5 clk -> out_sum held 16'h0007, in_ready=0
//    throughout, next stream accepted only after handshake, starts from 0.
//  3 Products -56,64 with in_last on 2nd -> out_sum=16'h0008, out_count=2.
//  4 ACC_W=9: four x 127 -> no SAT: out_sum=9'h1FC, out_ovf=1; with
//    BOOTH_ACC_SAT_EN: out_sum=9'h0FF, out_ovf=1.
//  5 clear after 2 accepts (5,5), then 1,1,1,1 -> out_sum=16'h0004; clear
//    in HOLD drops out_valid next clk.
//  6 rst_n low for 1 clk mid-stream -> outputs at reset values
//    asynchronously; following 4-term stream sums from 0.

Source files
------------

// File: rtl/booth_product_accumulator.sv
// Signed product accumulator: sums up to N_TERMS products per result over valid/ready handshakes.
// Optional macro BOOTH_ACC_SAT_EN makes each add saturate instead of wrapping.
module booth_product_accumulator #(
  parameter int P_W     = 8,
  parameter int ACC_W   = 16,
  parameter int N_TERMS = 4,
  localparam int CNT_W  = $clog2(N_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P_W-1:0]   in_product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {ST_ACCUM = 1'b0, ST_HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

`ifdef BOOTH_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum_raw;
  logic [ACC_W-1:0] sum_sel;
  logic             add_ovf;
  logic             accept;
  logic             close;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    prod_ext = {{(ACC_W-P_W){in_product[P_W-1]}}, in_product};
    sum_raw  = acc_q + prod_ext;
    // Overflow only possible when both operands share a sign.
    add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
               (sum_raw[ACC_W-1] != acc_q[ACC_W-1]);
`ifdef BOOTH_ACC_SAT_EN
    if (add_ovf) begin
      sum_sel = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_sel = sum_raw;
    end
`else
    sum_sel = sum_raw;
`endif
    cnt_inc = cnt_q + CNT_W'(1);
    accept  = in_valid && in_ready_q;
    close   = accept && (in_last || (cnt_q == LAST_CNT));
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (clear) begin
      state_d     = ST_ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept) begin
            acc_d = sum_sel;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | add_ovf;
          end
          if (close) begin
            state_d     = ST_HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_sum_d   = sum_sel;
            out_count_d = cnt_inc;
            out_ovf_d   = ovf_q | add_ovf;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_d     = ST_ACCUM;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = ST_ACCUM;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed bench for booth_product_accumulator: default 16-bit instance plus a 9-bit
// instance for the overflow/saturation case.
module tb_booth_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_product;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [2:0]  out_count;
  logic        out_ovf;

  logic        clear9;
  logic        in_valid9;
  logic        in_ready9;
  logic [7:0]  in_product9;
  logic        in_last9;
  logic        out_valid9;
  logic        out_ready9;
  logic [8:0]  out_sum9;
  logic [2:0]  out_count9;
  logic        out_ovf9;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_product_accumulator #(.P_W(8), .ACC_W(16), .N_TERMS(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  booth_product_accumulator #(.P_W(8), .ACC_W(9), .N_TERMS(4)) dut9 (
    .clk(clk), .rst_n(rst_n), .clear(clear9),
    .in_valid(in_valid9), .in_ready(in_ready9), .in_product(in_product9), .in_last(in_last9),
    .out_valid(out_valid9), .out_ready(out_ready9),
    .out_sum(out_sum9), .out_count(out_count9), .out_ovf(out_ovf9)
  );

  // Drive one product at a negedge and advance to the next negedge.
  task automatic send(input logic [7:0] p, input logic last);
    in_valid   = 1'b1;
    in_product = p;
    in_last    = last;
    @(negedge clk);
  endtask

  task automatic send9(input logic [7:0] p, input logic last);
    in_valid9   = 1'b1;
    in_product9 = p;
    in_last9    = last;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_product = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_product = 8'h00; in_last = 1'b0;
    out_ready = 1'b1;
    clear9 = 1'b0; in_valid9 = 1'b0; in_product9 = 8'h00; in_last9 = 1'b0; out_ready9 = 1'b1;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'h0000 ||
        out_count !== 3'd0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b sum=%h count=%0d ovf=%b, required 1 0 0000 0 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    send(8'd3, 1'b0); send(-8'sd2, 1'b0); send(8'd7, 1'b0); send(-8'sd1, 1'b0);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0007 || out_count !== 3'd4 ||
        out_ovf !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: valid=%b sum=%h count=%0d ovf=%b in_ready=%b, required 1 0007 4 0 0",
               out_valid, out_sum, out_count, out_ovf, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(8'd3, 1'b0); send(-8'sd2, 1'b0); send(8'd7, 1'b0); send(-8'sd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_product = 8'd100; in_last = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'h0007 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b sum=%h in_ready=%b, required 1 0007 0",
                 i, out_valid, out_sum, in_ready);
      end
      @(negedge clk);
    end
    idle();
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0004 || out_count !== 3'd4) begin
      errors++;
      $display("FAIL hold_next_stream: valid=%b sum=%h count=%0d, required 1 0004 4",
               out_valid, out_sum, out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_early_last();
    out_ready = 1'b1;
    send(-8'sd56, 1'b0); send(8'd64, 1'b1);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0008 || out_count !== 3'd2 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL early_last: valid=%b sum=%h count=%0d ovf=%b, required 1 0008 2 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow9();
    logic [8:0] exp_sum;
`ifdef BOOTH_ACC_SAT_EN
    exp_sum = 9'h0FF;
`else
    exp_sum = 9'h1FC;
`endif
    out_ready9 = 1'b1;
    send9(8'd127, 1'b0); send9(8'd127, 1'b0); send9(8'd127, 1'b0); send9(8'd127, 1'b0);
    in_valid9 = 1'b0;
    checks++;
    if (out_valid9 !== 1'b1 || out_sum9 !== exp_sum || out_count9 !== 3'd4 || out_ovf9 !== 1'b1) begin
      errors++;
      $display("FAIL acc9_overflow: valid=%b sum=%h count=%0d ovf=%b, required 1 %h 4 1",
               out_valid9, out_sum9, out_count9, out_ovf9, exp_sum);
    end
    @(negedge clk);
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    send(8'd5, 1'b0); send(8'd5, 1'b0);
    in_valid = 1'b1; in_product = 8'd50; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    idle();
    out_ready = 1'b0;
    send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0004 || out_count !== 3'd4) begin
      errors++;
      $display("FAIL clear_partial: valid=%b sum=%h count=%0d, required 1 0004 4",
               out_valid, out_sum, out_count);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_hold: valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    send(8'd2, 1'b1);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0002 || out_count !== 3'd1 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL clear_after: valid=%b sum=%h count=%0d ovf=%b, required 1 0002 1 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b0); send(8'd1, 1'b1);
    in_valid = 1'b1; in_product = 8'd9; in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0004 || out_count !== 3'd4) begin
      errors++;
      $display("FAIL b2b_both_close: valid=%b sum=%h count=%0d, required 1 0004 4",
               out_valid, out_sum, out_count);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_bubble: valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    in_last = 1'b1;
    @(negedge clk);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'h0009 || out_count !== 3'd1) begin
      errors++;
      $display("FAIL b2b_no_hold_accept: valid=%b sum=%h count=%0d, required 1 0009 1",
               out_valid, out_sum, out_count);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    send(8'd10, 1'b0); send(8'd20, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'h0000 ||
        out_count !== 3'd0 || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_mid: in_ready=%b valid=%b sum=%h count=%0d ovf=%b, required 1 0 0000 0 0",
               in_ready, out_valid, out_sum, out_count, out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd4, 1'b0);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 16'h000A || out_count !== 3'd4) begin
      errors++;
      $display("FAIL async_reset_restart: valid=%b sum=%h count=%0d, required 1 000a 4",
               out_valid, out_sum, out_count);
    end
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset_hold: valid=%b in_ready=%b sum=%h, required 0 1 0000",
               out_valid, in_ready, out_sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_early_last();
    test_overflow9();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
